// File: rtl/sramlike_axi_bridge.sv
// sramlike_axi_bridge
// Merges the instruction-side and data-side sram-like masters onto one
// single-beat AXI master port. The data side always wins arbitration and only
// one transaction is in flight at a time. Constant AXI fields (id, len, burst,
// last, lock, cache, prot) are tied off by the surrounding wrapper.
// Optional build macro: SRAMLIKE_AXI_ERR_EN adds the bus_err output, a
// one-cycle pulse alongside the completion when the slave answered with
// SLVERR or DECERR.

`timescale 1ns/1ps

module sramlike_axi_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    // instruction-side sram-like master (word reads only)
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,

    // data-side sram-like master
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [1:0]          data_size,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,

    // AXI read address / data channels
    output logic [ADDR_W-1:0]   araddr,
    output logic [2:0]          arsize,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready,

    // AXI write address / data / response channels
    output logic [ADDR_W-1:0]   awaddr,
    output logic [2:0]          awsize,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
`ifdef SRAMLIKE_AXI_ERR_EN
    ,
    output logic                bus_err
`endif
);

    localparam int STRB_W = DATA_W / 8;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_AR   = 3'd1;
    localparam logic [2:0] ST_R    = 3'd2;
    localparam logic [2:0] ST_AWW  = 3'd3;
    localparam logic [2:0] ST_B    = 3'd4;
    localparam logic [2:0] ST_RESP = 3'd5;

    logic [2:0]        state_q,   state_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [1:0]        size_q,    size_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic [STRB_W-1:0] wstrb_q,   wstrb_d;
    logic              owner_q,   owner_d;
    logic              awDone_q,  awDone_d;
    logic              wDone_q,   wDone_d;
    logic [DATA_W-1:0] rbuf_q,    rbuf_d;

    logic              idle;
    logic [ADDR_W-1:0] reqAddr;
    logic [1:0]        reqSize;
    logic [STRB_W-1:0] reqStrb;

    assign idle = (state_q == ST_IDLE);

    // Requests are only granted in IDLE; data side masks the instruction side.
    assign data_addr_ok = idle && data_req;
    assign inst_addr_ok = idle && inst_req && !data_req;

    // Select the winning request and derive its byte strobes from size/offset.
    always_comb begin
        reqAddr = data_req ? data_addr : inst_addr;
        reqSize = data_req ? data_size : 2'd2;
        reqStrb = '1;
        case (reqSize)
            2'd0:    reqStrb = STRB_W'(1) << reqAddr[1:0];
            2'd1:    reqStrb = STRB_W'(3) << {reqAddr[1], 1'b0};
            default: reqStrb = '1;
        endcase
    end

    // Transaction FSM: accept, run one AXI read or write, then a single
    // completion cycle before returning to IDLE.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        owner_d  = owner_q;
        awDone_d = awDone_q;
        wDone_d  = wDone_q;
        rbuf_d   = rbuf_q;
        case (state_q)
            ST_IDLE: begin
                awDone_d = 1'b0;
                wDone_d  = 1'b0;
                if (data_req || inst_req) begin
                    addr_d  = reqAddr;
                    size_d  = reqSize;
                    wdata_d = data_wdata;
                    wstrb_d = reqStrb;
                    owner_d = data_req;
                    state_d = (data_req && data_wr) ? ST_AWW : ST_AR;
                end
            end
            ST_AR: begin
                if (arready) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                if (rvalid) begin
                    rbuf_d  = rdata;
                    state_d = ST_RESP;
                end
            end
            ST_AWW: begin
                if (awready) begin
                    awDone_d = 1'b1;
                end
                if (wready) begin
                    wDone_d = 1'b1;
                end
                if (awDone_d && wDone_d) begin
                    state_d = ST_B;
                end
            end
            ST_B: begin
                if (bvalid) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and captured-request registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            owner_q  <= 1'b0;
            awDone_q <= 1'b0;
            wDone_q  <= 1'b0;
            rbuf_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            owner_q  <= owner_d;
            awDone_q <= awDone_d;
            wDone_q  <= wDone_d;
            rbuf_q   <= rbuf_d;
        end
    end

    // AXI channel drive: valids/readies follow the state, each write channel
    // drops on its own handshake.
    assign araddr  = addr_q;
    assign arsize  = {1'b0, size_q};
    assign arvalid = (state_q == ST_AR);
    assign rready  = (state_q == ST_R);

    assign awaddr  = addr_q;
    assign awsize  = {1'b0, size_q};
    assign awvalid = (state_q == ST_AWW) && !awDone_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wvalid  = (state_q == ST_AWW) && !wDone_q;
    assign bready  = (state_q == ST_B);

    // Completion goes only to the master that owns the transaction; both
    // masters see the shared read buffer.
    assign inst_data_ok = (state_q == ST_RESP) && !owner_q;
    assign data_data_ok = (state_q == ST_RESP) &&  owner_q;
    assign inst_rdata   = rbuf_q;
    assign data_rdata   = rbuf_q;

`ifdef SRAMLIKE_AXI_ERR_EN
    logic err_q, err_d;

    // Flag an error response at the same edge that enters RESP so the pulse
    // lines up with data_ok.
    always_comb begin
        err_d = ((state_q == ST_R) && rvalid && (rresp != 2'b00)) ||
                ((state_q == ST_B) && bvalid && (bresp != 2'b00));
    end

    // Registered one-cycle error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus_err = err_q;
`else
    logic unused_resp;
    assign unused_resp = ^{rresp, bresp};
`endif

endmodule
